// File: rtl/plant_sensor_model.sv
// rtl/plant_sensor_model.sv - first-order plant with saturating accumulator and noisy sensor readout
module plant_sensor_model #(
  parameter int          W          = 16,
  parameter int          MAX_VAL    = 32767,
  parameter int          MIN_VAL    = -32768,
  parameter int          GAIN_SHIFT = 7,
  parameter int          LEAK_SHIFT = 0,
  parameter int          DECIM      = 1,
  parameter int          NOISE_BITS = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                noise_en,
  input  logic signed [W-1:0] u_in,
  output logic signed [W-1:0] sensor_out,
  output logic                sample_valid
);

  localparam int A  = W + GAIN_SHIFT;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DECIM - 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic signed [A+1:0] ACC_MAX = {3'b000, {(A-1){1'b1}}};
  localparam logic signed [A+1:0] ACC_MIN = {3'b111, {(A-1){1'b0}}};
  localparam logic signed [W+1:0] OUT_MAX = (W+2)'(MAX_VAL);
  localparam logic signed [W+1:0] OUT_MIN = (W+2)'(MIN_VAL);

  logic [DW-1:0]               div_cnt;
  logic                        tick;
  logic                        out_pend;
  logic signed [A-1:0]         acc;
  logic signed [A-1:0]         leak;
  logic signed [A+1:0]         acc_sum;
  logic signed [A-1:0]         acc_next;
  logic [15:0]                 lfsr;
  logic [15:0]                 lfsr_next;
  logic signed [W-1:0]         plant_y;
  logic signed [NOISE_BITS-1:0] noise_raw;
  logic signed [W+1:0]         noise_ext;
  logic signed [W+1:0]         out_sum;
  logic signed [W-1:0]         out_next;

  assign tick = enable && (div_cnt == DIV_LAST);

  // Plant update: sum widened by two bits so the clamp sees true overflow, never a wrap.
  always_comb begin
    leak = '0;
    if (LEAK_SHIFT > 0) leak = acc >>> LEAK_SHIFT;
    acc_sum = $signed({{2{acc[A-1]}}, acc})
            + $signed({{(A+2-W){u_in[W-1]}}, u_in})
            - $signed({{2{leak[A-1]}}, leak});
    if (acc_sum > ACC_MAX)      acc_next = ACC_MAX[A-1:0];
    else if (acc_sum < ACC_MIN) acc_next = ACC_MIN[A-1:0];
    else                        acc_next = acc_sum[A-1:0];
  end

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // acc >>> GAIN_SHIFT always fits in W bits, so the upper slice is the floor shift.
  always_comb begin
    plant_y   = acc[A-1:GAIN_SHIFT];
    noise_raw = lfsr[NOISE_BITS-1:0];
    noise_ext = '0;
    if (noise_en) noise_ext = $signed({{(W+2-NOISE_BITS){noise_raw[NOISE_BITS-1]}}, noise_raw});
    out_sum = $signed({{2{plant_y[W-1]}}, plant_y}) + noise_ext;
    if (out_sum > OUT_MAX)      out_next = OUT_MAX[W-1:0];
    else if (out_sum < OUT_MIN) out_next = OUT_MIN[W-1:0];
    else                        out_next = out_sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      acc          <= '0;
      lfsr         <= SEED;
      out_pend     <= 1'b0;
      sensor_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (enable) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (tick) begin
        acc  <= acc_next;
        lfsr <= lfsr_next;
      end
      out_pend     <= tick;
      sample_valid <= out_pend;
      if (out_pend) sensor_out <= out_next;
    end
  end

endmodule
